// File: rtl/rs_issue_ctrl_if.sv
// rs_issue_ctrl_if
// Bus bundle between a reservation-station issue controller and the
// blocks around it (dispatcher, common data bus, execute unit,
// result broadcast).
//   master : environment side (dispatcher / CDB / execute unit)
//   slave  : reservation station side
// Signals:
//   in_*        dispatch of one instruction, full is the back-pressure reply
//   cdb_*       common-data-bus snoop
//   ex_*        registered operands to the combinational execute unit,
//               ex_result / ex_target_pc come back from it
//   out_*       registered result broadcast
interface rs_issue_ctrl_if #(
  parameter int ROB_ID_LEN = 4,
  parameter int OPENUM_LEN = 5,
  parameter int DATA_LEN   = 32,
  parameter int ADDR_LEN   = 32
);

  logic                  in_valid;
  logic [OPENUM_LEN-1:0] in_openum;
  logic [DATA_LEN-1:0]   in_V1;
  logic [DATA_LEN-1:0]   in_V2;
  logic [DATA_LEN-1:0]   in_imm;
  logic                  in_Q1_busy;
  logic                  in_Q2_busy;
  logic [ROB_ID_LEN-1:0] in_Q1;
  logic [ROB_ID_LEN-1:0] in_Q2;
  logic [ROB_ID_LEN-1:0] in_rob_id;
  logic [ADDR_LEN-1:0]   in_pc;
  logic                  full;

  logic                  cdb_valid;
  logic [ROB_ID_LEN-1:0] cdb_rob_id;
  logic [DATA_LEN-1:0]   cdb_result;

  logic [OPENUM_LEN-1:0] ex_openum;
  logic [DATA_LEN-1:0]   ex_V1;
  logic [DATA_LEN-1:0]   ex_V2;
  logic [DATA_LEN-1:0]   ex_imm;
  logic [ADDR_LEN-1:0]   ex_pc;
  logic [DATA_LEN-1:0]   ex_result;
  logic [ADDR_LEN-1:0]   ex_target_pc;

  logic                  out_valid;
  logic [ROB_ID_LEN-1:0] out_rob_id;
  logic [DATA_LEN-1:0]   out_result;
  logic [ADDR_LEN-1:0]   out_target_pc;

  modport master (
    output in_valid, in_openum, in_V1, in_V2, in_imm, in_Q1_busy, in_Q2_busy,
           in_Q1, in_Q2, in_rob_id, in_pc,
           cdb_valid, cdb_rob_id, cdb_result,
           ex_result, ex_target_pc,
    input  full, ex_openum, ex_V1, ex_V2, ex_imm, ex_pc,
           out_valid, out_rob_id, out_result, out_target_pc
  );

  modport slave (
    input  in_valid, in_openum, in_V1, in_V2, in_imm, in_Q1_busy, in_Q2_busy,
           in_Q1, in_Q2, in_rob_id, in_pc,
           cdb_valid, cdb_rob_id, cdb_result,
           ex_result, ex_target_pc,
    output full, ex_openum, ex_V1, ex_V2, ex_imm, ex_pc,
           out_valid, out_rob_id, out_result, out_target_pc
  );

endinterface

// File: rtl/rs_issue_ctrl.sv
// rs_issue_ctrl
// Reservation station with dispatch, CDB wake-up, single issue per cycle
// and a registered result broadcast.
// Ports:
//   clk      rising-edge clock
//   rst      synchronous active-high reset (beats rdy and rollback)
//   rdy      global enable, everything holds while low
//   rollback mispredict flush, frees all entries at the next edge
//   bus      rs_issue_ctrl_if.slave (dispatch, CDB, execute, broadcast)
// Optional feature:
//   RS_AGE_ORDER_EN  when defined, issue picks the oldest READY entry
//                    (8-bit saturating age), otherwise the lowest index.
module rs_issue_ctrl #(
  parameter int RS_SIZE    = 16,
  parameter int ROB_ID_LEN = 4,
  parameter int OPENUM_LEN = 5,
  parameter int DATA_LEN   = 32,
  parameter int ADDR_LEN   = 32
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           rdy,
  input  logic           rollback,
  rs_issue_ctrl_if.slave bus
);

  localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
  localparam int CNT_W = $clog2(RS_SIZE + 1);

  typedef enum logic [1:0] {S_FREE, S_WAIT, S_READY} entry_state_t;

  entry_state_t          st   [RS_SIZE];
  logic [OPENUM_LEN-1:0] op   [RS_SIZE];
  logic [DATA_LEN-1:0]   v1   [RS_SIZE];
  logic [DATA_LEN-1:0]   v2   [RS_SIZE];
  logic [DATA_LEN-1:0]   imm  [RS_SIZE];
  logic                  q1b  [RS_SIZE];
  logic                  q2b  [RS_SIZE];
  logic [ROB_ID_LEN-1:0] q1   [RS_SIZE];
  logic [ROB_ID_LEN-1:0] q2   [RS_SIZE];
  logic [ROB_ID_LEN-1:0] rob  [RS_SIZE];
  logic [ADDR_LEN-1:0]   pc   [RS_SIZE];
`ifdef RS_AGE_ORDER_EN
  logic [7:0]            age  [RS_SIZE];
  logic [7:0]            sel_age;
`endif

  logic                  free_found, sel_found;
  logic [IDX_W-1:0]      free_idx, sel_idx;
  logic [CNT_W-1:0]      free_cnt;
  logic [RS_SIZE-1:0]    hit1, hit2;
  logic                  d_q1b, d_q2b, d_hit1, d_hit2;
  logic [DATA_LEN-1:0]   d_v1, d_v2;
  logic                  do_dispatch, do_issue, full_n;

  logic                  ex_valid;
  logic [ROB_ID_LEN-1:0] ex_rob_id;
  logic [OPENUM_LEN-1:0] ex_openum_q;
  logic [DATA_LEN-1:0]   ex_v1_q, ex_v2_q, ex_imm_q;
  logic [ADDR_LEN-1:0]   ex_pc_q;
  logic                  out_valid_q, full_q;
  logic [ROB_ID_LEN-1:0] out_rob_id_q;
  logic [DATA_LEN-1:0]   out_result_q;
  logic [ADDR_LEN-1:0]   out_target_pc_q;

  // Free-slot search, issue select and CDB match, all from the state
  // held before the edge. Selecting from pre-edge state is what keeps an
  // entry woken at edge t from issuing before edge t+1.
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    free_cnt   = '0;
    sel_found  = 1'b0;
    sel_idx    = '0;
    hit1       = '0;
    hit2       = '0;
`ifdef RS_AGE_ORDER_EN
    sel_age    = '0;
`endif
    for (int i = 0; i < RS_SIZE; i++) begin
      if (st[i] == S_FREE) begin
        free_cnt = free_cnt + CNT_W'(1);
        if (!free_found) begin
          free_found = 1'b1;
          free_idx   = IDX_W'(i);
        end
      end
      if (st[i] == S_READY) begin
`ifdef RS_AGE_ORDER_EN
        if (!sel_found || (age[i] > sel_age)) begin
          sel_found = 1'b1;
          sel_idx   = IDX_W'(i);
          sel_age   = age[i];
        end
`else
        if (!sel_found) begin
          sel_found = 1'b1;
          sel_idx   = IDX_W'(i);
        end
`endif
      end
      hit1[i] = bus.cdb_valid && q1b[i] && (q1[i] == bus.cdb_rob_id);
      hit2[i] = bus.cdb_valid && q2b[i] && (q2[i] == bus.cdb_rob_id);
    end
  end

  // Dispatch-time bypass: a tag broadcast on the CDB in the dispatch
  // cycle is captured directly instead of leaving the operand busy.
  // A dispatch with no free slot is silently dropped.
  always_comb begin
    d_hit1      = bus.in_Q1_busy && bus.cdb_valid && (bus.in_Q1 == bus.cdb_rob_id);
    d_hit2      = bus.in_Q2_busy && bus.cdb_valid && (bus.in_Q2 == bus.cdb_rob_id);
    d_q1b       = bus.in_Q1_busy && !d_hit1;
    d_q2b       = bus.in_Q2_busy && !d_hit2;
    d_v1        = d_hit1 ? bus.cdb_result : bus.in_V1;
    d_v2        = d_hit2 ? bus.cdb_result : bus.in_V2;
    do_dispatch = bus.in_valid && free_found;
    do_issue    = sel_found;
    full_n      = (int'(free_cnt) - int'(do_dispatch) + int'(do_issue)) <= 1;
  end

  // Entry storage. The issued entry is READY and the dispatched entry is
  // FREE, so the three per-entry updates never target the same slot.
  always_ff @(posedge clk) begin
    if (rst || rollback) begin
      for (int i = 0; i < RS_SIZE; i++) begin
        st[i] <= S_FREE;
      end
    end else if (rdy) begin
      for (int i = 0; i < RS_SIZE; i++) begin
`ifdef RS_AGE_ORDER_EN
        if (age[i] != 8'hFF) age[i] <= age[i] + 8'd1;
`endif
        if (st[i] == S_WAIT) begin
          if (hit1[i]) begin
            v1[i]  <= bus.cdb_result;
            q1b[i] <= 1'b0;
          end
          if (hit2[i]) begin
            v2[i]  <= bus.cdb_result;
            q2b[i] <= 1'b0;
          end
          if ((!q1b[i] || hit1[i]) && (!q2b[i] || hit2[i])) st[i] <= S_READY;
        end
        if (do_issue && (sel_idx == IDX_W'(i))) st[i] <= S_FREE;
        if (do_dispatch && (free_idx == IDX_W'(i))) begin
          st[i]  <= (d_q1b || d_q2b) ? S_WAIT : S_READY;
          op[i]  <= bus.in_openum;
          v1[i]  <= d_v1;
          v2[i]  <= d_v2;
          imm[i] <= bus.in_imm;
          q1b[i] <= d_q1b;
          q2b[i] <= d_q2b;
          q1[i]  <= bus.in_Q1;
          q2[i]  <= bus.in_Q2;
          rob[i] <= bus.in_rob_id;
          pc[i]  <= bus.in_pc;
`ifdef RS_AGE_ORDER_EN
          age[i] <= 8'd0;
`endif
        end
      end
    end
  end

  // Issue latch, result broadcast and registered full flag. Rollback
  // only kills the valids and full; the stale payload is harmless.
  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid        <= 1'b0;
      ex_rob_id       <= '0;
      ex_openum_q     <= '0;
      ex_v1_q         <= '0;
      ex_v2_q         <= '0;
      ex_imm_q        <= '0;
      ex_pc_q         <= '0;
      out_valid_q     <= 1'b0;
      out_rob_id_q    <= '0;
      out_result_q    <= '0;
      out_target_pc_q <= '0;
      full_q          <= 1'b0;
    end else if (rollback) begin
      ex_valid    <= 1'b0;
      out_valid_q <= 1'b0;
      full_q      <= 1'b0;
    end else if (rdy) begin
      ex_valid <= do_issue;
      if (do_issue) begin
        ex_rob_id   <= rob[sel_idx];
        ex_openum_q <= op[sel_idx];
        ex_v1_q     <= v1[sel_idx];
        ex_v2_q     <= v2[sel_idx];
        ex_imm_q    <= imm[sel_idx];
        ex_pc_q     <= pc[sel_idx];
      end
      out_valid_q <= ex_valid;
      if (ex_valid) begin
        out_rob_id_q    <= ex_rob_id;
        out_result_q    <= bus.ex_result;
        out_target_pc_q <= bus.ex_target_pc;
      end
      full_q <= full_n;
    end
  end

  assign bus.full          = full_q;
  assign bus.ex_openum     = ex_openum_q;
  assign bus.ex_V1         = ex_v1_q;
  assign bus.ex_V2         = ex_v2_q;
  assign bus.ex_imm        = ex_imm_q;
  assign bus.ex_pc         = ex_pc_q;
  assign bus.out_valid     = out_valid_q;
  assign bus.out_rob_id    = out_rob_id_q;
  assign bus.out_result    = out_result_q;
  assign bus.out_target_pc = out_target_pc_q;

endmodule

// File: tb/tb_rs_issue_ctrl.sv
// tb_rs_issue_ctrl
// Scoreboard bench for rs_issue_ctrl: stimulus pushes the expected
// broadcast (including the cycle it must appear in) into a queue and an
// independent monitor pops and compares on every out_valid.
// The execute unit is modelled here: opcode 1 = ADDI (V1+imm),
// otherwise ADD (V1+V2); target pc = pc + 4.
module tb_rs_issue_ctrl;

  logic clk = 1'b0;
  logic rst, rdy, rollback;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int          cyc;
    logic [3:0]  rob;
    logic [31:0] res;
    logic [31:0] tpc;
  } exp_t;

  exp_t sb[$];

  rs_issue_ctrl_if bus ();

  rs_issue_ctrl dut (
    .clk      (clk),
    .rst      (rst),
    .rdy      (rdy),
    .rollback (rollback),
    .bus      (bus.slave)
  );

  // Clock and edge counter used to time expected broadcasts
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Combinational execute unit model
  assign bus.ex_result    = (bus.ex_openum == 5'd1) ? (bus.ex_V1 + bus.ex_imm) : (bus.ex_V1 + bus.ex_V2);
  assign bus.ex_target_pc = bus.ex_pc + 32'd4;

  task automatic checkOutput();
    exp_t e;
    checks++;
    if (sb.size() == 0) begin
      errors++;
      $display("[TB] FAIL unexpected_out got rob=%0d result=%h at cycle %0d, none expected",
               bus.out_rob_id, bus.out_result, cyc);
    end else begin
      e = sb.pop_front();
      if (bus.out_rob_id !== e.rob || bus.out_result !== e.res ||
          bus.out_target_pc !== e.tpc || cyc != e.cyc) begin
        errors++;
        $display("[TB] FAIL broadcast got rob=%0d result=%h tpc=%h cycle=%0d, expected rob=%0d result=%h tpc=%h cycle=%0d",
                 bus.out_rob_id, bus.out_result, bus.out_target_pc, cyc, e.rob, e.res, e.tpc, e.cyc);
      end
    end
  endtask

  task automatic checkSignal(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("[TB] FAIL %s got %h expected %h at cycle %0d", name, got, exp, cyc);
    end
  endtask

  // Monitor: compares every broadcast against the scoreboard
  always @(negedge clk) begin
    if (!rst && bus.out_valid) checkOutput();
  end

  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] v1, input logic [31:0] v2,
                               input logic [31:0] imm, input logic q1b, input logic [3:0] q1,
                               input logic q2b, input logic [3:0] q2, input logic [3:0] rob,
                               input logic [31:0] pc);
    bus.in_valid   = 1'b1;
    bus.in_openum  = op;
    bus.in_V1      = v1;
    bus.in_V2      = v2;
    bus.in_imm     = imm;
    bus.in_Q1_busy = q1b;
    bus.in_Q1      = q1;
    bus.in_Q2_busy = q2b;
    bus.in_Q2      = q2;
    bus.in_rob_id  = rob;
    bus.in_pc      = pc;
  endtask

  task automatic driveCdb(input logic [3:0] tag, input logic [31:0] res);
    bus.cdb_valid  = 1'b1;
    bus.cdb_rob_id = tag;
    bus.cdb_result = res;
  endtask

  task automatic clearInputs();
    bus.in_valid  = 1'b0;
    bus.cdb_valid = 1'b0;
  endtask

  task automatic expectOut(input int c, input logic [3:0] rob, input logic [31:0] res, input logic [31:0] tpc);
    exp_t e;
    e.cyc = c; e.rob = rob; e.res = res; e.tpc = tpc;
    sb.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    int k;
    rst = 1'b1; rdy = 1'b1; rollback = 1'b0;
    applyStimulus(5'd0, 0, 0, 0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 0);
    clearInputs();
    bus.cdb_rob_id = '0; bus.cdb_result = '0;
    tick(3);
    checkSignal("reset_full", 32'(bus.full), 32'd0);
    checkSignal("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkSignal("reset_ex_V1", bus.ex_V1, 32'd0);
    checkSignal("reset_ex_pc", bus.ex_pc, 32'd0);
    checkSignal("reset_out_result", bus.out_result, 32'd0);
    checkSignal("reset_out_rob_id", 32'(bus.out_rob_id), 32'd0);
    rst = 1'b0;
    tick(1);

    // ADDI 5+3, no busy operands
    k = cyc;
    applyStimulus(5'd1, 32'd5, 32'd0, 32'd3, 1'b0, 4'd0, 1'b0, 4'd0, 4'd1, 32'h100);
    expectOut(k + 3, 4'd1, 32'd8, 32'h104);
    tick(1); clearInputs(); tick(4);

    // ADD with Q1 busy, woken by CDB later
    applyStimulus(5'd0, 32'd0, 32'd7, 32'd0, 1'b1, 4'd3, 1'b0, 4'd0, 4'd2, 32'h200);
    tick(1); clearInputs(); tick(2);
    k = cyc;
    driveCdb(4'd3, 32'd10);
    expectOut(k + 3, 4'd2, 32'd17, 32'h204);
    tick(1); clearInputs(); tick(4);

    // Dispatch bypass from the CDB in the same cycle
    k = cyc;
    applyStimulus(5'd0, 32'd0, 32'd1, 32'd0, 1'b1, 4'd2, 1'b0, 4'd0, 4'd5, 32'h300);
    driveCdb(4'd2, 32'h40);
    expectOut(k + 3, 4'd5, 32'h41, 32'h304);
    tick(1); clearInputs(); tick(4);

    // CDB while rdy is low must not be captured
    applyStimulus(5'd0, 32'd0, 32'd2, 32'd0, 1'b1, 4'd6, 1'b0, 4'd0, 4'd7, 32'h400);
    tick(1); clearInputs(); rdy = 1'b0; driveCdb(4'd6, 32'd100);
    tick(1); clearInputs(); rdy = 1'b1;
    tick(2);
    k = cyc;
    driveCdb(4'd6, 32'd50);
    expectOut(k + 3, 4'd7, 32'd52, 32'h404);
    tick(1); clearInputs(); tick(4);

    // Concurrent dispatch, CDB wake-up, issue and broadcast
    applyStimulus(5'd0, 32'd0, 32'd3, 32'd0, 1'b1, 4'd10, 1'b0, 4'd0, 4'd11, 32'h500);
    tick(1); clearInputs(); tick(1);
    k = cyc;
    applyStimulus(5'd1, 32'd1, 32'd0, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd8, 32'h510);
    tick(1);
    applyStimulus(5'd1, 32'd2, 32'd0, 32'd2, 1'b0, 4'd0, 1'b0, 4'd0, 4'd9, 32'h520);
    driveCdb(4'd10, 32'd20);
    expectOut(k + 3, 4'd8, 32'd2, 32'h514);
    expectOut(k + 4, 4'd11, 32'd23, 32'h504);
    expectOut(k + 5, 4'd9, 32'd4, 32'h524);
    tick(1); clearInputs(); tick(5);

    // Select order: older entry at higher index vs younger at index 0
    k = cyc;
    applyStimulus(5'd0, 32'd0, 32'd0, 32'd0, 1'b1, 4'd14, 1'b0, 4'd0, 4'd14, 32'h800);
    tick(1);
    applyStimulus(5'd0, 32'd0, 32'd1, 32'd0, 1'b1, 4'd12, 1'b0, 4'd0, 4'd12, 32'h600);
    tick(1); clearInputs();
    driveCdb(4'd14, 32'd5);
    expectOut(k + 5, 4'd14, 32'd5, 32'h804);
    tick(1); clearInputs(); tick(1);
    applyStimulus(5'd1, 32'd9, 32'd0, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd13, 32'h700);
    driveCdb(4'd12, 32'd4);
`ifdef RS_AGE_ORDER_EN
    expectOut(k + 7, 4'd12, 32'd5, 32'h604);
    expectOut(k + 8, 4'd13, 32'd10, 32'h704);
`else
    expectOut(k + 7, 4'd13, 32'd10, 32'h704);
    expectOut(k + 8, 4'd12, 32'd5, 32'h604);
`endif
    tick(1); clearInputs(); tick(6);

    // Fill RS_SIZE-1 WAIT entries; full must rise on the last one
    for (int i = 0; i < 15; i++) begin
      applyStimulus(5'd0, 32'd0, 32'(i), 32'd0, 1'b1, 4'd15, 1'b0, 4'd0, 4'(i), 32'h1000);
      tick(1);
      if (i == 13) checkSignal("full_at_two_free", 32'(bus.full), 32'd0);
      if (i == 14) checkSignal("full_at_one_free", 32'(bus.full), 32'd1);
    end
    // Dispatch in the cycle full rose is still accepted
    k = cyc;
    applyStimulus(5'd1, 32'h20, 32'd0, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd0, 32'h900);
    expectOut(k + 3, 4'd0, 32'h21, 32'h904);
    tick(1);
    checkSignal("full_when_no_free", 32'(bus.full), 32'd1);
    // No free entry: this dispatch must vanish without side effects
    applyStimulus(5'd1, 32'hdead, 32'd0, 32'd0, 1'b0, 4'd0, 1'b0, 4'd0, 4'd3, 32'hbad0);
    tick(1); clearInputs(); tick(1);
    // In-flight instruction then rollback before its broadcast
    applyStimulus(5'd1, 32'd1, 32'd0, 32'd1, 1'b0, 4'd0, 1'b0, 4'd0, 4'd4, 32'ha00);
    tick(1); clearInputs(); tick(1);
    rollback = 1'b1;
    tick(1);
    rollback = 1'b0;
    checkSignal("rollback_full", 32'(bus.full), 32'd0);
    checkSignal("rollback_out_valid", 32'(bus.out_valid), 32'd0);
    // Flushed WAIT entries must not wake up
    driveCdb(4'd15, 32'd1);
    tick(1); clearInputs(); tick(4);
    checkSignal("post_rollback_full", 32'(bus.full), 32'd0);

    // Reset mid-flight discards the in-flight result
    applyStimulus(5'd1, 32'd7, 32'd0, 32'd7, 1'b0, 4'd0, 1'b0, 4'd0, 4'd6, 32'hb00);
    tick(1); clearInputs(); rst = 1'b1;
    tick(1); rst = 1'b0;
    checkSignal("midreset_out_valid", 32'(bus.out_valid), 32'd0);
    checkSignal("midreset_ex_V1", bus.ex_V1, 32'd0);
    tick(5);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL missing_out got %0d broadcasts outstanding, expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
